rr_mux2_sequencer: RTL

RR_MUX2_SEQUENCER -- requirements
Module: rr_mux2_sequencer

---
 rtl/rr_mux2_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/rr_mux2_sequencer.sv
// Round-robin 2:1 mux feeding one output register; the result is visible one cycle after acceptance.
// Backpressure: a full, stalled register blocks both inputs; a register that drains is refilled in the same cycle.
module rr_mux2_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             s0,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] y_data_q;
  logic [WIDTH-1:0] y_data_d;
  logic             s0_q;
  logic             prio_q;
  logic [7:0]       xfer_cnt_q;

  logic load_en;
  logic grant_a;
  logic grant_b;
  logic grant;
  logic drain;

  // prio_q names the channel that wins when both inputs are valid
  always_comb begin
    load_en  = (state_q == EMPTY) | y_ready;
    grant_a  = load_en & a_valid & (~b_valid | ~prio_q);
    grant_b  = load_en & b_valid & (~a_valid | prio_q);
    grant    = grant_a | grant_b;
    drain    = (state_q == FULL) & y_ready;
    y_data_d = grant_b ? b_data : a_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      y_data_q   <= '0;
      s0_q       <= 1'b0;
      prio_q     <= 1'b0;
      xfer_cnt_q <= 8'd0;
    end else begin
      if (drain) begin
        xfer_cnt_q <= xfer_cnt_q + 8'd1;
      end
      if (grant) begin
        state_q  <= FULL;
        y_data_q <= y_data_d;
        s0_q     <= grant_b;
        prio_q   <= grant_a;
      end else if (drain) begin
        state_q <= EMPTY;
      end
    end
  end

  // Readies are combinational, so they must be masked while reset is held
  assign a_ready  = rst_n & grant_a;
  assign b_ready  = rst_n & grant_b;
  assign y_valid  = (state_q == FULL);
  assign y_data   = y_data_q;
  assign s0       = s0_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule
